// File: rtl/ret_stack.sv
// ret_stack: hardware return-address stack for the call/return path.
// A call pushes the return address, and a return pops it. The top of stack
// drives the PC-source mux combinationally from registered state only. The
// block also reports the depth and two sticky error flags (overflow and
// underflow) to the control unit.
module ret_stack #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clr_err,
  input  logic [WIDTH-1:0]           D,
  output logic [WIDTH-1:0]           Q,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] IDX_ONE   = AW'(1);

  // Storage and state registers.
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic             r_underflow;

  // Decoded next-state controls.
  logic             w_empty;
  logic             w_full;
  logic [AW-1:0]    w_top_idx;
  logic             w_wr_en;
  logic [AW-1:0]    w_wr_idx;
  logic [AW:0]      w_count_nxt;
  logic             w_set_ovf;
  logic             w_set_unf;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_DEPTH);

  // The low AW bits of the count wrap to zero when the stack is full.
  // Subtracting one from them therefore still lands on DEPTH-1, which is
  // the correct top entry.
  assign w_top_idx = r_count[AW-1:0] - IDX_ONE;

  // Work out this edge's write, count update and error raises from push and pop.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_wr_en     = 1'b0;
    w_wr_idx    = r_count[AW-1:0];
    w_count_nxt = r_count;
    w_set_ovf   = 1'b0;
    w_set_unf   = 1'b0;
    unique case ({push, pop})
      2'b10: begin
        if (w_full) begin
          w_set_ovf = 1'b1;
        end else begin
          w_wr_en     = 1'b1;
          w_wr_idx    = r_count[AW-1:0];
          w_count_nxt = r_count + CNT_ONE;
        end
      end
      2'b01: begin
        if (w_empty) begin
          w_set_unf = 1'b1;
        end else begin
          w_count_nxt = r_count - CNT_ONE;
        end
      end
      2'b11: begin
        if (w_empty) begin
          // Pop on an empty stack is rejected; the push half still lands.
          w_wr_en     = 1'b1;
          w_wr_idx    = '0;
          w_count_nxt = CNT_ONE;
          w_set_unf   = 1'b1;
        end else begin
          // Return-then-call collapses to replacing the top entry.
          w_wr_en  = 1'b1;
          w_wr_idx = w_top_idx;
        end
      end
      default: ;
    endcase
  end

  // Write the array. It has no reset because the count alone decides which entries are visible.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; Q is forced to 0 while empty, so stale contents never leak out.
    if (!reset && w_wr_en) begin
      r_mem[w_wr_idx] <= D;
    end
  end

  // Count and sticky error flags; reset has priority, and a raise beats clr_err.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_overflow  <= (r_overflow  & ~clr_err) | w_set_ovf;
      r_underflow <= (r_underflow & ~clr_err) | w_set_unf;
    end
  end

  assign Q         = w_empty ? '0 : r_mem[w_top_idx];
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: doc/ret_stack.md
# ret_stack

Hardware return-address stack for the processor's subroutine call/return path. On a call, the control unit pushes the return address (the 10-bit PC+1 from the PC adder). On a return, it pops, and the top-of-stack value feeds the PC-source multiplexer that loads the PC register. The block sits between the PC incrementer (upstream, supplies D) and the PC mux/register (downstream, consumes Q). It also reports stack-depth and error status to the control unit.

## Interface

Parameters:
- WIDTH, 10: address width; matches the PC/adder width.
- DEPTH, 16: number of entries; must be a power of two and at least 2.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  reset, synchronous, active-high; sampled on the rising edge of clk.
- push  input  1  push D this cycle (call).
- pop  input  1  pop top entry this cycle (return).
- clr_err  input  1  clear the sticky error flags.
- D  input  WIDTH  return address to push.
- Q  output  WIDTH  current top-of-stack; 0 when empty.
- count  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky; set by a rejected push.
- underflow  output  1  sticky; set by a rejected pop.

## Operation

- **Storage:**
  - DEPTH x WIDTH register array plus a count register.
  - Entry index count-1 is the top.
  - Array contents are not reset.
- **Q:** combinational read of the top entry, forced to 0 when count == 0. Q never shows stale data.
- **empty, full:** combinational decodes of count.
- **Per-edge actions**, evaluated in priority order:
  - reset=1: count=0, overflow=0, underflow=0. push, pop and clr_err are ignored.
  - push=1, pop=0, not full: write D at index count; count+1.
  - push=1, pop=0, full: no write; count unchanged; overflow=1.
  - push=0, pop=1, not empty: count-1. The array is unchanged.
  - push=0, pop=1, empty: count stays 0; underflow=1.
  - push=1, pop=1, not empty: replace the top entry (index count-1) with D; count unchanged. This applies when full as well; no overflow is raised.
  - push=1, pop=1, empty: treated as a push (write index 0, count=1); underflow=1.
  - push=0, pop=0: state unchanged.
- **clr_err=1:** clears overflow and underflow on the same edge.
  - Exception: if the same edge also raises an error, the raise wins and that flag reads 1 afterwards.
- **Arithmetic:** count never wraps. It saturates via the rules above and never exceeds DEPTH or goes below 0.

## Timing

- **Reset:** after the reset edge, Q=0, count=0, empty=1, full=0, overflow=0, underflow=0.
- **Latency:** zero-latency read, one-cycle write.
  - A push at edge k makes Q=D, with count incremented, immediately after edge k.
  - A pop at edge k exposes the previous entry on Q immediately after edge k.
- **Back-to-back:** push and pop may be asserted on consecutive cycles, and a push may follow a pop immediately. No bubbles are required.
- **Reset mid-operation:** reset overrides any simultaneous push or pop on the same edge. The stack is logically emptied, and old array data is never visible on Q afterwards.
- **No combinational path** from push, pop or D to Q. Q depends only on registered state.

## Test plan

- **Reset:** hold reset=1 for 2 edges with push=1 and D=10'h155. Required: Q=0, count=0, empty=1, both flags 0.
- **Fill and drain:** push 10'h001..10'h010 on 16 consecutive edges.
  - After the fill: full=1, count=16, Q=10'h010.
  - Then pop 16 times; Q steps 10'h00F..10'h001 and finally 0, with empty=1.
- **Overflow:**
  - Push 17 values with DEPTH=16. Required: the 17th is ignored, overflow=1, Q still shows the 16th value, count=16.
  - Then assert clr_err for 1 edge. Required: overflow=0.
- **Underflow and simultaneous push/pop on empty:**
  - Pop when empty. Required: underflow=1, count=0, Q=0.
  - Then push=pop=1 with D=10'h2AA. Required: count=1, Q=10'h2AA, underflow still 1.
- **Replace top:**
  - Push 10'h100 then 10'h200, then assert push=pop=1 with D=10'h3FF. Required: count=2, Q=10'h3FF.
  - Then pop. Required: Q=10'h100.
- **Mid-operation reset:** push 3 values, then assert reset together with pop=1. Required: count=0 and Q=0 after that edge; a following push of 10'h0AB gives Q=10'h0AB with count=1.
